// File: rtl/mips32_disp_pkg.sv
// Shared types and helpers for the register display path.
// Optional build macro: BCD_SIGNED_EN (two's complement operand + sign flag).
package mips32_disp_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int BCD_W = 4;

  // ceil(width * log10(2)) in integer arithmetic
  function automatic int min_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/reg_bcd_converter_if.sv
// Operand handshake and BCD result bundle of the display converter.
// Optional build macro: BCD_SIGNED_EN adds the sign signal.
interface reg_bcd_converter_if
  import mips32_disp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);

  logic [WIDTH-1:0]        in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [BCD_W*DIGITS-1:0] bcd_out;
  logic                    bcd_valid;
  logic                    busy;
  logic                    ovf;
`ifdef BCD_SIGNED_EN
  logic                    sign;
`endif

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  bcd_out,
    input  bcd_valid,
    input  busy,
    input  ovf
`ifdef BCD_SIGNED_EN
    ,
    input  sign
`endif
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output bcd_out,
    output bcd_valid,
    output busy,
    output ovf
`ifdef BCD_SIGNED_EN
    ,
    output sign
`endif
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Shift-and-add-3 correction for one BCD nibble.
// Optional build macro: BCD_SIGNED_EN (no effect here).
module bcd_digit_adj
  import mips32_disp_pkg::*;
(
  input  logic [BCD_W-1:0] nib,
  output logic [BCD_W-1:0] adj
);

  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/reg_bcd_converter.sv
// Sequential binary-to-BCD converter for the register display.
// Optional build macro: BCD_SIGNED_EN (signed operand, sign output).
module reg_bcd_converter
  import mips32_disp_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DIGITS         = 10,
  parameter int SHOWN_DIGITS   = 8,
  parameter int ONLY_ON_CHANGE = 1
) (
  input  logic clk,
  input  logic rst,
  reg_bcd_converter_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int BW    = BCD_W * DIGITS;

  generate
    if (DIGITS < min_digits(WIDTH)) begin : g_chk
      $error("DIGITS too small for WIDTH");
    end
  endgenerate

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shf;
  logic [WIDTH-1:0] shf_nx;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] oper;
  logic [WIDTH-1:0] last;
  logic             have_last;
  logic [BW-1:0]    work;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    bcd_nx;
  logic             ovf_nx;
  logic             hs;
  logic             skip;
  logic             load;
  logic             done;
  logic             unused_msb;
`ifdef BCD_SIGNED_EN
  logic             sign_pend;
`endif

  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state == SHIFT);

  assign hs   = bus.in_valid && bus.in_ready;
  assign skip = (ONLY_ON_CHANGE != 0) && have_last
             && (bus.in_data == last);

`ifdef BCD_SIGNED_EN
  // -2^(WIDTH-1) negates to itself, which reads correctly as unsigned
  assign mag = bus.in_data[WIDTH-1] ? -bus.in_data
                                    : bus.in_data;
`else
  assign mag = bus.in_data;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib (work[i*BCD_W +: BCD_W]),
      .adj (adj[i*BCD_W +: BCD_W])
    );
  end

  assign bcd_nx     = {adj[BW-2:0], shf[WIDTH-1]};
  assign shf_nx     = {shf[WIDTH-2:0], 1'b0};
  assign unused_msb = adj[BW-1];

  always_comb begin
    ovf_nx = 1'b0;
    for (int i = SHOWN_DIGITS; i < DIGITS; i++) begin
      ovf_nx = ovf_nx | (|bcd_nx[i*BCD_W +: BCD_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (hs && !skip) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      shf           <= '0;
      work          <= '0;
      oper          <= '0;
      last          <= '0;
      have_last     <= 1'b0;
      bus.bcd_out   <= '0;
      bus.bcd_valid <= 1'b0;
      bus.ovf       <= 1'b0;
`ifdef BCD_SIGNED_EN
      sign_pend     <= 1'b0;
      bus.sign      <= 1'b0;
`endif
    end else begin
      bus.bcd_valid <= done;
      if (load) begin
        shf  <= mag;
        work <= '0;
        cnt  <= CNT_W'(WIDTH - 1);
        oper <= bus.in_data;
`ifdef BCD_SIGNED_EN
        sign_pend <= bus.in_data[WIDTH-1];
`endif
      end else if (state == SHIFT) begin
        shf  <= shf_nx;
        work <= bcd_nx;
        cnt  <= cnt - 1'b1;
      end
      if (done) begin
        bus.bcd_out <= bcd_nx;
        bus.ovf     <= ovf_nx;
        last        <= oper;
        have_last   <= 1'b1;
`ifdef BCD_SIGNED_EN
        bus.sign    <= sign_pend;
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_bcd_converter.sv
// Directed bench for reg_bcd_converter (skip-on-repeat and always-convert DUTs).
// Optional build macro: BCD_SIGNED_EN selects the signed expectations.
module tb_reg_bcd_converter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  reg_bcd_converter_if #(.WIDTH(32), .DIGITS(10)) bus0 ();
  reg_bcd_converter_if #(.WIDTH(32), .DIGITS(10)) bus1 ();

  assign bus1.in_data  = bus0.in_data;
  assign bus1.in_valid = bus0.in_valid;

  reg_bcd_converter #(.ONLY_ON_CHANGE(1)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  reg_bcd_converter #(.ONLY_ON_CHANGE(0)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] v);
    int t = 0;
    while (!bus0.in_ready && t < 100) begin
      tick();
      t++;
    end
    if (!bus0.in_ready) chk("ready_timeout", 0, 1);
    bus0.in_data  = v;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus0.bcd_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic convert(input string tag,
                         input logic [31:0] v,
                         input logic [39:0] exp,
                         input logic exp_ovf,
                         input logic exp_sign);
    int lat;
    accept(v);
    chk({tag, "_busy"}, bus0.busy, 1);
    chk({tag, "_rdy_low"}, bus0.in_ready, 0);
    wait_done(lat);
    chk({tag, "_latency"}, lat, 32);
    chk({tag, "_bcd"}, bus0.bcd_out, exp);
    chk({tag, "_ovf"}, bus0.ovf, exp_ovf);
    chk({tag, "_bcd_u1"}, bus1.bcd_out, exp);
`ifdef BCD_SIGNED_EN
    chk({tag, "_sign"}, bus0.sign, exp_sign);
`else
    if (exp_sign) chk({tag, "_sign_unexp"}, 0, 1);
`endif
    tick();
    chk({tag, "_pulse_end"}, bus0.bcd_valid, 0);
  endtask

  int low;
  int p0;
  int p1;
  int lat;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.in_data  = '0;
    bus0.in_valid = 1'b0;
    tick();
    tick();
    chk("rst_ready", bus0.in_ready, 1);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_valid", bus0.bcd_valid, 0);
    chk("rst_bcd", bus0.bcd_out, 0);
    chk("rst_ovf", bus0.ovf, 0);
`ifdef BCD_SIGNED_EN
    chk("rst_sign", bus0.sign, 0);
`endif
    rst = 1'b0;

    convert("zero", 32'd0, 40'h0, 0, 0);
    convert("d12345678", 32'd12345678,
            40'h0012345678, 0, 0);
    convert("d99999999", 32'd99999999,
            40'h0099999999, 0, 0);
    convert("d100000000", 32'd100000000,
            40'h0100000000, 1, 0);
`ifdef BCD_SIGNED_EN
    convert("all_ones", 32'hFFFFFFFF, 40'h1, 0, 1);
    convert("min_neg", 32'h80000000,
            40'h2147483648, 1, 1);
`else
    convert("all_ones", 32'hFFFFFFFF,
            40'h4294967295, 1, 0);
    convert("top_bit", 32'h80000000,
            40'h2147483648, 1, 0);
`endif

    // back-to-back with in_valid held high
    bus0.in_data  = 32'd5;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_data = 32'd7;
    low = 0;
    p0  = 0;
    repeat (32) begin
      if (!bus0.in_ready) low++;
      if (bus0.bcd_valid) p0++;
      tick();
    end
    chk("b2b_rdy_low", low, 32);
    chk("b2b_early", p0, 0);
    chk("b2b_valid5", bus0.bcd_valid, 1);
    chk("b2b_rdy5", bus0.in_ready, 1);
    chk("b2b_bcd5", bus0.bcd_out, 40'h5);
`ifdef BCD_SIGNED_EN
    chk("b2b_sign5", bus0.sign, 0);
`endif
    tick();
    bus0.in_valid = 1'b0;
    chk("b2b_busy7", bus0.busy, 1);
    chk("b2b_drop5", bus0.bcd_valid, 0);
    wait_done(lat);
    chk("b2b_lat7", lat, 32);
    chk("b2b_bcd7", bus0.bcd_out, 40'h7);
    p0 = 0;
    repeat (5) begin
      tick();
      if (bus0.bcd_valid) p0++;
    end
    chk("b2b_dup", p0, 0);

    // reset in the 10th shift cycle
    accept(32'd1234);
    repeat (9) tick();
    chk("abort_busy_pre", bus0.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_bcd", bus0.bcd_out, 0);
    chk("abort_ovf", bus0.ovf, 0);
    chk("abort_busy", bus0.busy, 0);
    chk("abort_ready", bus0.in_ready, 1);
    chk("abort_valid", bus0.bcd_valid, 0);
    p0 = 0;
    repeat (40) begin
      tick();
      if (bus0.bcd_valid || bus1.bcd_valid) p0++;
    end
    chk("abort_no_pulse", p0, 0);
    convert("d99", 32'd99, 40'h99, 0, 0);

    // repeat suppression
    convert("d42", 32'd42, 40'h42, 0, 0);
    accept(32'd42);
    chk("rep_busy", bus0.busy, 0);
    chk("rep_ready", bus0.in_ready, 1);
    chk("rep_busy_u1", bus1.busy, 1);
    p0 = 0;
    p1 = 0;
    repeat (40) begin
      if (bus0.bcd_valid) p0++;
      if (bus1.bcd_valid) p1++;
      tick();
    end
    chk("rep_pulse_u0", p0, 0);
    chk("rep_pulse_u1", p1, 1);
    chk("rep_bcd_u0", bus0.bcd_out, 40'h42);
    chk("rep_bcd_u1", bus1.bcd_out, 40'h42);
    convert("d43", 32'd43, 40'h43, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
